// File: rtl/serial_sim_rx.sv
// Oversampling serial receiver: 16x-baud line recovery of start/8-bit MSB-first/parity frames,
// delivered through a 4-entry valid/ready FIFO with sticky overrun.
module serial_sim_rx #(
    parameter int unsigned PARITY_EN = 1,
    parameter int unsigned STOP_BITS = 0
) (
    input  logic       baud16,
    input  logic       rst,
    input  logic       rxd,
    output logic [7:0] rx_data,
    output logic       rx_perr,
    output logic       rx_ferr,
    output logic       rx_valid,
    input  logic       rx_ready,
    output logic       overrun,
    output logic       busy
);

    localparam int unsigned DATA_W = 8;
    localparam int unsigned DEPTH  = 4;
    localparam int unsigned PTR_W  = 2;
    localparam int unsigned CNT_W  = 3;
    localparam int unsigned TICK_W = 4;
    localparam int unsigned BITN_W = 3;

    localparam logic [TICK_W-1:0] TICK_MID  = TICK_W'(7);
    localparam logic [TICK_W-1:0] TICK_END  = TICK_W'(15);
    localparam logic [BITN_W-1:0] LAST_BIT  = BITN_W'(7);
    localparam bit                HAS_PAR   = (PARITY_EN != 0);
    localparam bit                HAS_STOP  = (STOP_BITS != 0);

    typedef struct packed {
        logic              ferr;
        logic              perr;
        logic [DATA_W-1:0] data;
    } rx_entry_t;

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP,
        S_GAP
    } state_t;

    state_t              r_state;
    state_t              w_next;
    logic                r_sync1;
    logic                r_sync2;
    logic                w_rxs;
    logic [TICK_W-1:0]   r_cnt;
    logic [BITN_W-1:0]   r_bitn;
    logic [DATA_W-1:0]   r_sr;
    logic                r_perr;
    logic                r_busy;
    logic                w_shift;
    logic                w_par_smp;
    logic                w_push;
    rx_entry_t           w_entry;

    rx_entry_t           r_mem [DEPTH];
    logic [PTR_W-1:0]    r_wr;
    logic [PTR_W-1:0]    r_rd;
    logic [CNT_W-1:0]    r_count;
    rx_entry_t           r_head;
    logic                r_valid;
    logic                r_ovr;
    logic                w_pop;
    logic                w_full;
    logic                w_wr_en;
    logic                w_drop;
    logic [PTR_W-1:0]    w_rd_nxt;
    logic [CNT_W-1:0]    w_count_nxt;
    rx_entry_t           w_head_nxt;

    assign w_rxs = r_sync2;

    // State register
    always_ff @(posedge baud16) begin
        if (!rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next state, sample strobes and the entry pushed on the final frame bit.
    // GAP/STOP jump straight to START on a low line so back-to-back frames keep alignment.
    always_comb begin
        w_next    = r_state;
        w_shift   = 1'b0;
        w_par_smp = 1'b0;
        w_push    = 1'b0;
        w_entry   = '0;
        case (r_state)
            S_IDLE: begin
                if (!w_rxs) w_next = S_START;
            end
            S_START: begin
                if (r_cnt == TICK_MID) w_next = w_rxs ? S_IDLE : S_DATA;
            end
            S_DATA: begin
                if (r_cnt == TICK_END) begin
                    w_shift = 1'b1;
                    if (r_bitn == LAST_BIT) begin
                        if (HAS_PAR) begin
                            w_next = S_PARITY;
                        end else if (HAS_STOP) begin
                            w_next = S_STOP;
                        end else begin
                            w_next       = S_GAP;
                            w_push       = 1'b1;
                            w_entry.data = {r_sr[DATA_W-2:0], w_rxs};
                        end
                    end
                end
            end
            S_PARITY: begin
                if (r_cnt == TICK_END) begin
                    w_par_smp = 1'b1;
                    if (HAS_STOP) begin
                        w_next = S_STOP;
                    end else begin
                        w_next       = S_GAP;
                        w_push       = 1'b1;
                        w_entry.perr = w_rxs ^ (^r_sr);
                        w_entry.data = r_sr;
                    end
                end
            end
            S_STOP: begin
                if (r_cnt == TICK_END) begin
                    w_push       = 1'b1;
                    w_entry.ferr = ~w_rxs;
                    w_entry.perr = r_perr;
                    w_entry.data = r_sr;
                    w_next       = w_rxs ? S_IDLE : S_START;
                end
            end
            S_GAP: begin
                if (r_cnt == TICK_MID) w_next = w_rxs ? S_IDLE : S_START;
            end
            default: w_next = S_IDLE;
        endcase
    end

    // Synchronizer, tick counter and frame datapath
    always_ff @(posedge baud16) begin
        if (!rst) begin
            r_sync1 <= 1'b1;
            r_sync2 <= 1'b1;
            r_cnt   <= '0;
            r_bitn  <= '0;
            r_sr    <= '0;
            r_perr  <= 1'b0;
            r_busy  <= 1'b0;
        end else begin
            r_sync1 <= rxd;
            r_sync2 <= r_sync1;
            r_cnt   <= (w_next != r_state) ? '0 : r_cnt + TICK_W'(1);
            r_busy  <= (r_state != S_IDLE);
            if (r_state == S_START) begin
                r_bitn <= '0;
            end else if (w_shift) begin
                r_bitn <= r_bitn + BITN_W'(1);
            end
            if (w_shift) r_sr <= {r_sr[DATA_W-2:0], w_rxs};
            if (w_par_smp) r_perr <= w_rxs ^ (^r_sr);
        end
    end

    // FIFO control; the head is pre-computed so the outputs come straight from flops
    assign w_pop       = r_valid & rx_ready;
    assign w_full      = (r_count == CNT_W'(DEPTH));
    assign w_wr_en     = w_push & (~w_full | w_pop);
    assign w_drop      = w_push & w_full & ~w_pop;
    assign w_rd_nxt    = r_rd + PTR_W'(w_pop);
    assign w_count_nxt = r_count + CNT_W'(w_wr_en) - CNT_W'(w_pop);
    assign w_head_nxt  = (w_wr_en && (r_wr == w_rd_nxt)) ? w_entry : r_mem[w_rd_nxt];

    always_ff @(posedge baud16) begin
        if (w_wr_en) r_mem[r_wr] <= w_entry;
    end

    always_ff @(posedge baud16) begin
        if (!rst) begin
            r_wr    <= '0;
            r_rd    <= '0;
            r_count <= '0;
            r_head  <= '0;
            r_valid <= 1'b0;
            r_ovr   <= 1'b0;
        end else begin
            if (w_wr_en) r_wr <= r_wr + PTR_W'(1);
            r_rd    <= w_rd_nxt;
            r_count <= w_count_nxt;
            r_head  <= w_head_nxt;
            r_valid <= (w_count_nxt != '0);
            if (w_pop) begin
                r_ovr <= 1'b0;
            end else if (w_drop) begin
                r_ovr <= 1'b1;
            end
        end
    end

    assign rx_data  = r_head.data;
    assign rx_perr  = r_head.perr;
    assign rx_ferr  = r_head.ferr;
    assign rx_valid = r_valid;
    assign overrun  = r_ovr;
    assign busy     = r_busy;

endmodule

// File: tb/tb_serial_sim_rx.sv
// Self-checking bench for serial_sim_rx: directed frames plus randomized traffic against a queue model.
module tb_serial_sim_rx;

    logic       clk;
    logic       rst_n;
    logic       rxd;
    logic [7:0] rx_data;
    logic       rx_perr;
    logic       rx_ferr;
    logic       rx_valid;
    logic       rx_ready;
    logic       overrun;
    logic       busy;

    int         n_checks;
    int         n_errors;
    int         cyc;
    bit         mon_en;
    bit         rand_mode;
    logic       ready_cmd;
    bit         exp_ovr;
    logic [9:0] exp_q [$];

    // rxd low at a negedge reaches rxs after 2 edges; rx_valid then rises 153 cycles later
    localparam int unsigned H_LATENCY = 2 + 153;

    serial_sim_rx dut (
        .baud16   (clk),
        .rst      (rst_n),
        .rxd      (rxd),
        .rx_data  (rx_data),
        .rx_perr  (rx_perr),
        .rx_ferr  (rx_ferr),
        .rx_valid (rx_valid),
        .rx_ready (rx_ready),
        .overrun  (overrun),
        .busy     (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc++;

    always @(posedge clk) begin
        #1;
        rx_ready = rand_mode ? 1'($urandom_range(0, 1)) : ready_cmd;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got=%0h expected=%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Reference: each frame yields {ferr=0, perr=inverted parity, data}; a full FIFO drops it
    task automatic model_push(input logic [7:0] d, input bit bad_par);
        if (exp_q.size() < 4) exp_q.push_back({1'b0, bad_par, d});
        else exp_ovr = 1'b1;
    endtask

    task automatic send_frame(input logic [7:0] d, input bit bad_par);
        logic [9:0] bits;
        model_push(d, bad_par);
        bits = {1'b0, d, (^d) ^ bad_par};
        for (int i = 9; i >= 0; i--) begin
            rxd = bits[i];
            repeat (16) @(negedge clk);
        end
    endtask

    task automatic idle(input int n);
        rxd = 1'b1;
        repeat (n) @(negedge clk);
    endtask

    task automatic drain(input string tag);
        for (int k = 0; k < 3000 && exp_q.size() != 0; k++) @(negedge clk);
        chk(tag, 32'(exp_q.size()), 32'd0);
    endtask

    always @(negedge clk) begin
        if (mon_en && rst_n && rx_valid && rx_ready) begin
            logic [9:0] e;
            chk("entry_expected", 32'(exp_q.size() != 0), 32'd1);
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                chk("rx_data", 32'(rx_data), 32'(e[7:0]));
                chk("rx_perr", 32'(rx_perr), 32'(e[8]));
                chk("rx_ferr", 32'(rx_ferr), 32'(e[9]));
                chk("overrun_at_pop", 32'(overrun), 32'(exp_ovr));
                exp_ovr = 1'b0;
            end
        end
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic [7:0] hi [8];
        int         t0;
        int         lat;
        hi = '{8'h48, 8'h69, 8'h54, 8'h68, 8'h65, 8'h72, 8'h65, 8'h20};
        n_checks  = 0;
        n_errors  = 0;
        cyc       = 0;
        mon_en    = 1'b0;
        rand_mode = 1'b0;
        ready_cmd = 1'b1;
        exp_ovr   = 1'b0;
        rst_n     = 1'b0;
        rxd       = 1'b1;

        // Reset while the line toggles
        repeat (4) begin
            @(negedge clk);
            rxd = ~rxd;
        end
        chk("rst_valid", 32'(rx_valid), 32'd0);
        chk("rst_data", 32'(rx_data), 32'd0);
        chk("rst_perr", 32'(rx_perr), 32'd0);
        chk("rst_ferr", 32'(rx_ferr), 32'd0);
        chk("rst_overrun", 32'(overrun), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        rxd   = 1'b1;
        rst_n = 1'b1;
        repeat (4) @(negedge clk);
        mon_en = 1'b1;

        // Single 'H' frame and its first-valid latency
        idle(20);
        t0  = cyc;
        lat = -1;
        fork
            send_frame(8'h48, 1'b0);
            begin
                for (int k = 0; k < 400; k++) begin
                    @(negedge clk);
                    if (rx_valid) begin
                        lat = cyc - t0;
                        break;
                    end
                end
            end
        join
        idle(40);
        chk("h_latency", 32'(lat), 32'(H_LATENCY));
        drain("drain_h");

        // Back-to-back "HiThere ", clean and then with the parity of 'i' inverted
        for (int pass = 0; pass < 2; pass++) begin
            for (int i = 0; i < 8; i++) send_frame(hi[i], (pass == 1) && (i == 1));
            idle(40);
            drain("drain_hithere");
        end

        // Short glitch: false start, nothing pushed
        idle(20);
        rxd = 1'b0;
        repeat (5) @(negedge clk);
        rxd = 1'b1;
        repeat (3) @(negedge clk);
        chk("glitch_busy_high", 32'(busy), 32'd1);
        repeat (22) @(negedge clk);
        chk("glitch_busy_low", 32'(busy), 32'd0);
        idle(200);
        chk("glitch_no_valid", 32'(rx_valid), 32'd0);

        // Reset in the middle of a frame abandons it
        rxd = 1'b0;
        repeat (40) @(negedge clk);
        rst_n = 1'b0;
        rxd   = 1'b1;
        repeat (2) @(negedge clk);
        chk("midrst_busy", 32'(busy), 32'd0);
        rst_n = 1'b1;
        idle(200);
        chk("midrst_no_valid", 32'(rx_valid), 32'd0);

        // Five frames into a stalled consumer: four held, one dropped
        ready_cmd = 1'b0;
        idle(4);
        for (int i = 0; i < 5; i++) send_frame(8'($urandom), ($urandom_range(0, 3) == 0));
        idle(30);
        chk("ovr_set", 32'(overrun), 32'd1);
        chk("ovr_valid", 32'(rx_valid), 32'd1);
        chk("ovr_model_full", 32'(exp_q.size()), 32'd4);
        ready_cmd = 1'b1;
        drain("drain_overrun");
        idle(4);
        chk("ovr_cleared", 32'(overrun), 32'd0);
        chk("ovr_empty", 32'(rx_valid), 32'd0);

        // Randomized traffic, random gaps and a random consumer
        rand_mode = 1'b1;
        for (int i = 0; i < 24; i++) begin
            send_frame(8'($urandom), ($urandom_range(0, 5) == 0));
            if ($urandom_range(0, 1) == 1) idle($urandom_range(1, 40));
        end
        idle(40);
        drain("drain_random");
        rand_mode = 1'b0;
        idle(10);
        chk("final_overrun", 32'(overrun), 32'd0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/serial_sim_rx.md
# serial_sim_rx

Receive-side companion to the serial text-stream transmitter model. Oversamples a 16x-baud serial line, recovers 8-bit characters framed as start bit, 8 data bits MSB-first, and an even-parity bit (optional stop bit), then delivers them through a 4-entry FIFO with a valid/ready handshake. It sits directly downstream of the transmitter model on `txd`, in both simulation benches and on-chip loopback.

## Interface
- `PARITY_EN`, default 1: 1 means a parity bit follows the data bits and is checked; 0 means there is no parity bit.
- `STOP_BITS`, default 0: 0 means the next start bit may immediately follow the last frame bit; 1 means one stop bit is required and checked.
- `baud16`  in  1  clock, 16x bit rate; the only clock.
- `rst`  in  1  reset, synchronous, active-low (0 = reset).
- `rxd`  in  1  serial line, idle high; asynchronous to `baud16`.
- `rx_data`  out  8  head-of-FIFO character.
- `rx_perr`  out  1  head character failed the parity check.
- `rx_ferr`  out  1  head character had a low stop bit.
- `rx_valid`  out  1  FIFO non-empty.
- `rx_ready`  in  1  consumer accepts the head entry on a cycle where `rx_valid & rx_ready`.
- `overrun`  out  1  sticky: a completed frame was dropped because the FIFO was full.
- `busy`  out  1  frame reception in progress (any state other than IDLE).

## Operation
- Synchronizer: two flops on `rxd`, both reset to 1. All logic uses the synchronized `rxs`.
- Tick counter `cnt`, 4 bits. It wraps 15→0. It is cleared on every state entry.
- States:
  - IDLE: when `rxs==0`, go to START.
  - START: when `cnt==7`, sample `rxs`. If 1, this is a false start: return to IDLE with no output. If 0, go to DATA with `bitn=0`.
  - DATA: when `cnt==15`, shift in MSB-first (`sr <= {sr[6:0],rxs}`) and increment `bitn`. After the 8th sample, go to PARITY if `PARITY_EN`, else STOP if `STOP_BITS`, else GAP.
  - PARITY: when `cnt==15`, `perr = rxs ^ (^sr)`. The expected parity bit equals the XOR of the data bits. Then go to STOP or GAP.
  - STOP: when `cnt==15`, `ferr = ~rxs`, then go to IDLE. A line held low after a framing error re-enters START immediately.
  - GAP: wait until `cnt==7` (end of the last bit cell), then go to IDLE. This allows back-to-back frames with no stop bit even when the parity bit is 0.
- Push:
  - The FIFO entry `{ferr,perr,sr}` is pushed on the cycle the final frame bit is sampled: the parity sample, the stop sample, or the 8th data sample.
  - `ferr` is 0 when `STOP_BITS==0`.
  - `perr` is 0 when `PARITY_EN==0`.
- FIFO: 4 entries, 2-bit read/write pointers plus a 3-bit count.
  - Pop when `rx_valid & rx_ready`.
  - Push while full and no pop: the entry is dropped and `overrun` is set.
  - Push and pop in the same cycle while full: both succeed, no overrun.
  - Push and pop in the same cycle while empty: the push lands; `rx_valid` rises the next cycle.
- `overrun` clears on the first pop after it was set.
- `rx_data`, `rx_perr`, `rx_ferr` show the head entry and are only meaningful while `rx_valid=1`.

## Timing
- Reset values (applied when `rst==0` at a clock edge):
  - Outputs: `rx_valid=0`, `rx_data=0`, `rx_perr=0`, `rx_ferr=0`, `overrun=0`, `busy=0`.
  - Internal: FSM in IDLE, FIFO empty, synchronizer = 1.
- Reset mid-frame abandons the frame; nothing is pushed.
- Input latency: 2 cycles through the synchronizer.
- The start edge is confirmed 8 cycles after `rxs` falls. Each later bit is sampled 16 cycles after the previous one, which is the bit-cell centre.
- Push cycle:
  - Parity enabled: 8 + 16·9 = 152 cycles after `rxs` falls.
  - Parity disabled, no stop bit: 136 cycles.
- `rx_valid` rises 1 cycle after the push.
- IDLE is re-entered 160 cycles after the falling edge (PARITY_EN=1, STOP_BITS=0). This matches a 10-bit, 160-cycle frame with zero slack.
- Tolerated baud mismatch: ±1 tick accumulated drift over a frame.
- `busy` is high from the cycle after START entry until IDLE is re-entered.

## Test plan
- Reset with `rst=0` for 4 cycles while `rxd` toggles → all outputs 0, no FIFO entries.
- Single frame 'H': line bits 0,0,1,0,0,1,0,0,0,0 at 16 cycles/bit, with the line idling high before and after → one entry, `rx_data=8'h48`, `perr=0`, `rx_valid` high 153 cycles after `rxs` falls.
- Back-to-back "HiThere " with no gaps, `rx_ready=1` → 8 entries in order 48,69,54,68,65,72,65,20, all with `perr=0`, `ferr=0`.
- Parity bit inverted on 'i' → `rx_data=8'h69`, `rx_perr=1`. The neighbouring frames are clean.
- Glitch: `rxd` low for 5 cycles, then high → returns to IDLE, nothing pushed, `busy` deasserts.
- `rx_ready=0` while 5 frames arrive → FIFO holds the first 4 and `overrun=1`. Then assert `rx_ready` → the first 4 characters drain in order, and `overrun` clears after the first pop.
